// File: rtl/sar_scan_sequencer.sv
// SAR scan sequencer: walks the enabled ADC channels, sampling each and then running
// N_BIT MSB-first bit trials with a latch strobe per bit. Optional macro SAR_CONT_SCAN_EN adds continuous rescans.
module sar_scan_sequencer #(
   parameter int N_ADC      = 8,
   parameter int N_BIT      = 10,
   parameter int SAMPLE_CYC = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SAR_CONT_SCAN_EN
   input  logic             cont,
   output logic [7:0]       scan_cnt,
`endif
   input  logic             start,
   input  logic             abort,
   input  logic [N_ADC-1:0] ch_mask,
   output logic [N_ADC-1:0] adc_sel,
   output logic [N_BIT-1:0] bit_sel,
   output logic             sample,
   output logic             latch_en,
   output logic             busy,
   output logic             done
);

   localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [N_ADC-1:0] ADC_ONE     = N_ADC'(1);
   localparam logic [N_BIT-1:0] BIT_MSB     = {1'b1, {(N_BIT-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SAMPLE = 2'd1,
      S_TRIAL  = 2'd2,
      S_LATCH  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [N_ADC-1:0] ch_sel_q, ch_sel_d;
   logic [N_BIT-1:0] bit_sel_q, bit_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_ADC-1:0] mask_q, mask_d;
   logic             done_q, done_d;
`ifdef SAR_CONT_SCAN_EN
   logic [7:0]       scan_cnt_q, scan_cnt_d;
`endif

   logic [N_ADC-1:0] mask_first;
   logic [N_ADC-1:0] remaining;
   logic [N_ADC-1:0] next_ch;

   // x & -x isolates the lowest set bit; remaining drops the current channel and all below it
   assign mask_first = ch_mask & (~ch_mask + ADC_ONE);
   assign remaining  = mask_q & ~(ch_sel_q | (ch_sel_q - ADC_ONE));
   assign next_ch    = remaining & (~remaining + ADC_ONE);

   always_comb begin
      state_d   = state_q;
      ch_sel_d  = ch_sel_q;
      bit_sel_d = bit_sel_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      done_d    = 1'b0;
`ifdef SAR_CONT_SCAN_EN
      scan_cnt_d = scan_cnt_q;
`endif
      if (abort) begin
         state_d   = S_IDLE;
         ch_sel_d  = '0;
         bit_sel_d = '0;
         cnt_d     = '0;
         mask_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (ch_mask != '0)) begin
                  mask_d   = ch_mask;
                  ch_sel_d = mask_first;
                  cnt_d    = '0;
                  state_d  = S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               if (cnt_q == SAMPLE_LAST) begin
                  cnt_d     = '0;
                  bit_sel_d = BIT_MSB;
                  state_d   = S_TRIAL;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_TRIAL: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d   = '0;
                  state_d = S_LATCH;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_LATCH: begin
               cnt_d = '0;
               if (!bit_sel_q[0]) begin
                  bit_sel_d = bit_sel_q >> 1;
                  state_d   = S_TRIAL;
               end else if (next_ch != '0) begin
                  ch_sel_d  = next_ch;
                  bit_sel_d = '0;
                  state_d   = S_SAMPLE;
               end else begin
                  // last bit of last channel: scan complete
                  done_d    = 1'b1;
                  bit_sel_d = '0;
`ifdef SAR_CONT_SCAN_EN
                  scan_cnt_d = scan_cnt_q + 8'd1;
                  if (cont && (ch_mask != '0)) begin
                     mask_d   = ch_mask;
                     ch_sel_d = mask_first;
                     state_d  = S_SAMPLE;
                  end else begin
                     mask_d   = '0;
                     ch_sel_d = '0;
                     state_d  = S_IDLE;
                  end
`else
                  mask_d   = '0;
                  ch_sel_d = '0;
                  state_d  = S_IDLE;
`endif
               end
            end
            default: begin
               state_d   = S_IDLE;
               ch_sel_d  = '0;
               bit_sel_d = '0;
               cnt_d     = '0;
               mask_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ch_sel_q  <= '0;
         bit_sel_q <= '0;
         cnt_q     <= '0;
         mask_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_sel_q  <= ch_sel_d;
         bit_sel_q <= bit_sel_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         done_q    <= done_d;
      end
   end

`ifdef SAR_CONT_SCAN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt_q <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
      end
   end

   assign scan_cnt = scan_cnt_q;
`endif

   assign adc_sel  = ch_sel_q;
   assign bit_sel  = bit_sel_q;
   assign sample   = (state_q == S_SAMPLE);
   assign latch_en = (state_q == S_LATCH);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Directed bench for sar_scan_sequencer: latch/done events go through an expected queue
// popped by a negedge monitor; directed spot checks cover idle, abort and reset behaviour.
module tb_sar_scan_sequencer;

   localparam int N_ADC      = 8;
   localparam int N_BIT      = 10;
   localparam int SAMPLE_CYC = 4;
   localparam int SETTLE_CYC = 2;
   localparam int PER_CH     = SAMPLE_CYC + N_BIT * (SETTLE_CYC + 1);
   localparam int NO_STOP    = 1000000;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [N_ADC-1:0] ch_mask;
   logic [N_ADC-1:0] adc_sel;
   logic [N_BIT-1:0] bit_sel;
   logic             sample;
   logic             latch_en;
   logic             busy;
   logic             done;
`ifdef SAR_CONT_SCAN_EN
   logic             cont;
   logic [7:0]       scan_cnt;
`endif

   sar_scan_sequencer #(
      .N_ADC(N_ADC), .N_BIT(N_BIT), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef SAR_CONT_SCAN_EN
      .cont(cont),
      .scan_cnt(scan_cnt),
`endif
      .start(start),
      .abort(abort),
      .ch_mask(ch_mask),
      .adc_sel(adc_sel),
      .bit_sel(bit_sel),
      .sample(sample),
      .latch_en(latch_en),
      .busy(busy),
      .done(done)
   );

   // clock / reset / cycle index
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   // event word: {is_done, cycle[12:0], adc_sel, bit_sel}
   function automatic logic [31:0] pack(input logic kind, input int c,
                                        input logic [7:0] a, input logic [9:0] b);
      logic [31:0] w;
      w = {kind, c[12:0], a, b};
      return w;
   endfunction

   function automatic logic [31:0] outs();
      return {10'd0, busy, done, sample, latch_en, adc_sel, bit_sel};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected events for a scan whose start is applied in cycle c0
   task automatic push_scan(input int c0, input logic [7:0] mask, input int stop_cyc,
                            input logic [7:0] done_adc);
      int cur;
      int lc;
      cur = c0 + 1;
      for (int ch = 0; ch < N_ADC; ch++) begin
         if (mask[ch]) begin
            for (int b = 0; b < N_BIT; b++) begin
               lc = cur + SAMPLE_CYC + b * (SETTLE_CYC + 1) + SETTLE_CYC;
               if (lc <= stop_cyc)
                  exp_q.push_back(pack(1'b0, lc, 8'(1 << ch), 10'(10'h200 >> b)));
            end
            cur = cur + PER_CH;
         end
      end
      if (cur <= stop_cyc)
         exp_q.push_back(pack(1'b1, cur, done_adc, 10'h000));
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // monitor: every latch strobe or done pulse must match the head of the queue
   logic [31:0] mon_act;
   logic [31:0] mon_exp;
   always @(negedge clk) begin
      if (latch_en || done) begin
         mon_act = pack(done, cyc, adc_sel, bit_sel);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %h expected none (cycle %0d)", mon_act, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp || (latch_en && (done || sample || !busy))) begin
               n_bad++;
               $display("FAIL scan_event: got %h (lat=%0b smp=%0b busy=%0b) expected %h (cycle %0d)",
                        mon_act, latch_en, sample, busy, mon_exp, cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int  c0;
   int  c1;
   logic bad_seen;

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      ch_mask = '0;
`ifdef SAR_CONT_SCAN_EN
      cont    = 1'b0;
`endif
      repeat (3) tick();
      check("reset_outs", outs(), 32'd0);
`ifdef SAR_CONT_SCAN_EN
      check("reset_scan_cnt", 32'(scan_cnt), 32'd0);
`endif
      reset = 1'b0;
      tick();

      // single channel, with a start re-pulse at cycle 10
      ch_mask = 8'h01;
      start   = 1'b1;
      c0      = cyc;
      push_scan(c0, 8'h01, NO_STOP, 8'h00);
      tick();
      start = 1'b0;
      check("single_c1_sample", outs(), {10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 10'h000});
      wait_until(c0 + 5);
      check("single_c5_trial", outs(), {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 10'h200});
      wait_until(c0 + 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_drain("single_drain", 100);
      check("single_idle_after", outs(), 32'd0);

      // sparse mask, mask changed mid-scan
      ch_mask = 8'h81;
      start   = 1'b1;
      c0      = cyc;
      push_scan(c0, 8'h81, NO_STOP, 8'h00);
      tick();
      start = 1'b0;
      wait_until(c0 + 20);
      ch_mask = 8'hFF;
      wait_until(c0 + 40);
      check("sparse_c40_ch7", 32'(adc_sel), 32'h80);
      wait_drain("sparse_drain", 200);
      check("sparse_idle_after", outs(), 32'd0);

      // empty mask: start held high, nothing happens
      ch_mask  = 8'h00;
      start    = 1'b1;
      bad_seen = 1'b0;
      repeat (50) begin
         tick();
         if (busy || done || adc_sel != '0) bad_seen = 1'b1;
      end
      start = 1'b0;
      check("empty_mask_idle", 32'(bad_seen), 32'd0);

      // abort in a trial cycle, then a fresh full scan
      ch_mask = 8'h03;
      start   = 1'b1;
      c0      = cyc;
      push_scan(c0, 8'h03, c0 + 20, 8'h00);
      tick();
      start = 1'b0;
      wait_until(c0 + 20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_outs", outs(), 32'd0);
      check("abort_events", 32'(exp_q.size()), 32'd0);
      wait_until(c0 + 25);
      start = 1'b1;
      c1    = cyc;
      push_scan(c1, 8'h03, NO_STOP, 8'h00);
      tick();
      start = 1'b0;
      wait_drain("rescan_drain", 150);
      check("rescan_idle_after", outs(), 32'd0);

      // abort during a latch cycle: the strobe is not repeated
      ch_mask = 8'h01;
      start   = 1'b1;
      c0      = cyc;
      push_scan(c0, 8'h01, c0 + 7, 8'h00);
      tick();
      start = 1'b0;
      wait_until(c0 + 7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_latch_outs", outs(), 32'd0);
      repeat (5) tick();
      check("abort_latch_events", 32'(exp_q.size()), 32'd0);

      // start and abort together in idle: abort wins
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", outs(), 32'd0);
      repeat (3) tick();
      check("start_abort_idle_later", outs(), 32'd0);

      // asynchronous reset mid-scan
      start = 1'b1;
      c0    = cyc;
      push_scan(c0, 8'h01, c0 + 14, 8'h00);
      tick();
      start = 1'b0;
      wait_until(c0 + 15);
      reset = 1'b1;
      #1;
      check("async_reset_outs", outs(), 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("after_reset_idle", outs(), 32'd0);
      check("after_reset_events", 32'(exp_q.size()), 32'd0);

`ifdef SAR_CONT_SCAN_EN
      // continuous scans: three done pulses, busy held until the last one
      ch_mask = 8'h01;
      cont    = 1'b1;
      start   = 1'b1;
      c0      = cyc;
      push_scan(c0, 8'h01, NO_STOP, 8'h01);
      push_scan(c0 + PER_CH, 8'h01, NO_STOP, 8'h01);
      push_scan(c0 + 2 * PER_CH, 8'h01, NO_STOP, 8'h00);
      tick();
      start = 1'b0;
      wait_until(c0 + 36);
      check("cont_cnt1", {23'd0, busy, scan_cnt}, {23'd0, 1'b1, 8'd1});
      wait_until(c0 + 70);
      check("cont_cnt2", {23'd0, busy, scan_cnt}, {23'd0, 1'b1, 8'd2});
      wait_until(c0 + 101);
      cont = 1'b0;
      wait_until(c0 + 103);
      check("cont_final", {23'd0, busy, scan_cnt}, {23'd0, 1'b0, 8'd3});
      wait_drain("cont_drain", 50);
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sar_scan_sequencer.md
Name: sar_scan_sequencer

Overview:
- Controller that drives the ADC writer/register datapath.
- Sequences SAR conversions across the 8 ADC channels: sample, then 10 MSB-first bit trials per channel.
- Generates one-hot channel select (to ADCctrl) and one-hot bit select (to bitctrl), plus a per-bit latch strobe.
- Sits between the system control logic (start/mask) and the writer.

Parameters:
- N_ADC, 8, number of ADC channels; width of adc_sel and ch_mask.
- N_BIT, 10, bits per SAR conversion; width of bit_sel.
- SAMPLE_CYC, 4, cycles the sample phase is held per channel (>=1).
- SETTLE_CYC, 2, DAC/comparator settle cycles per bit trial before the latch cycle (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled in IDLE only.
- abort  in  1  terminate the scan; takes priority over everything except reset.
- ch_mask  in  N_ADC  channels to convert; bit i enables ADC i.
- adc_sel  out  N_ADC  one-hot active channel (to writer ADCctrl); 0 when idle.
- bit_sel  out  N_BIT  one-hot bit under trial (to writer bitctrl); 0 when idle or sampling.
- sample  out  1  high during the sample phase.
- latch_en  out  1  one-cycle strobe; writer captures the selected bit.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes normally.

Behaviour:
- Reset state: IDLE. All outputs 0, internal counters 0, latched mask 0.
- States: IDLE, SAMPLE, TRIAL, LATCH.
- IDLE:
  - start=1 with ch_mask!=0 latches ch_mask, selects the lowest enabled channel and moves to SAMPLE.
  - start with ch_mask==0 is ignored; stay IDLE, no busy, no done.
- SAMPLE:
  - adc_sel is one-hot, sample=1, bit_sel=0, for exactly SAMPLE_CYC cycles.
  - Then go to TRIAL with bit_sel=1<<(N_BIT-1).
- TRIAL:
  - adc_sel and bit_sel held for SETTLE_CYC cycles, then go to LATCH.
- LATCH:
  - Lasts 1 cycle with latch_en=1; adc_sel and bit_sel unchanged.
  - If the bit is not bit 0: bit_sel shifts right by one and the state returns to TRIAL.
  - If it is bit 0: advance to the next higher enabled channel in the latched mask and go to SAMPLE.
  - If no enabled channel remains: go to IDLE, pulse done for 1 cycle, drop busy and all selects in that same cycle.
- busy is high in SAMPLE, TRIAL and LATCH.
- Latency:
  - Per channel: SAMPLE_CYC + N_BIT*(SETTLE_CYC+1) cycles. Defaults give 34.
  - Scan length: popcount(mask) × per-channel cycles.
  - done appears in the cycle immediately after the final LATCH.
- Changes to ch_mask during a scan are ignored; the latched copy is used.
- start while busy is ignored.
- abort (any non-IDLE state): next cycle goes to IDLE with all outputs 0 and no done. A latch_en that was high in the abort cycle is not repeated.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Reset asserted mid-scan: outputs clear immediately (asynchronous), no done.
- adc_sel and bit_sel are never multi-hot. Both are registered outputs (no combinational path from inputs).

Optional Feature:
- Macro: SAR_CONT_SCAN_EN.
- Defined:
  - Adds input port cont (1 bit) and output scan_cnt (8 bits, reset 0, increments on each done, wraps 255->0).
  - If cont=1 in the final LATCH cycle, done still pulses, but the sequencer re-latches ch_mask and goes directly to SAMPLE of the lowest enabled channel. busy stays high.
  - If the re-latched mask is 0, go to IDLE instead.
- Undefined: no cont or scan_cnt ports; every scan is single-shot as above.

Test Plan:
- Single channel: defaults, ch_mask=0x01, start pulse in cycle 0 -> adc_sel=0x01 cycles 1-34; sample cycles 1-4; bit_sel=0x200 cycles 5-7; latch_en at cycles 7,10,...,34 (10 pulses); done at cycle 35 only; busy cycles 1-34.
- Sparse mask: ch_mask=0x81 -> channel 0 for 34 cycles, then adc_sel=0x80 for 34 cycles, done at cycle 69, 20 latch_en pulses total. Changing ch_mask to 0xFF mid-scan has no effect.
- Empty mask: ch_mask=0x00, start=1 -> busy, done, adc_sel stay 0 for 50 cycles.
- Abort: ch_mask=0x03, abort at cycle 20 -> cycle 21 all outputs 0, no done. A new start at cycle 25 runs a full 68-cycle scan.
- Start while busy / reset: start re-pulsed at cycle 10 -> ignored, done still at cycle 35. Async reset asserted at cycle 15 -> outputs 0 before the next clk edge.
- SAR_CONT_SCAN_EN: cont=1, ch_mask=0x01 -> done at cycles 35, 69, 103; busy never drops; scan_cnt counts 1, 2, 3. cont=0 before cycle 102 -> busy drops at cycle 103.
